// File: rtl/pipeline_core_if.sv
// Bundle of the program-load and write-back observation signals of pipeline_core.
// The master side loads programs and observes; the slave side is the core.
interface pipeline_core_if #(
  parameter int DATA_W  = 32,
  parameter int IMEM_AW = 4
);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic [DATA_W-1:0]  result;
  logic               wb_valid;
  logic [4:0]         wb_reg;
  logic [IMEM_AW-1:0] pc;
  logic               stall;
  logic               halted;

  modport master (
    output imem_we, imem_addr, imem_wdata,
    input  result, wb_valid, wb_reg, pc, stall, halted
  );

  modport slave (
    input  imem_we, imem_addr, imem_wdata,
    output result, wb_valid, wb_reg, pc, stall, halted
  );
endinterface

// File: rtl/pipeline_core.sv
// Five-stage in-order MIPS-style core with forwarding, load-use stall, data memory,
// HALT and a program-load port; write-back results are exposed for observation.
module pipeline_core #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16
) (
  input logic            clk,
  input logic            reset,
  pipeline_core_if.slave bus
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} aluOp_t;

  typedef struct packed {
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              halt;
    logic              useImm;
    aluOp_t            aluOp;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] rtVal;
    logic [DATA_W-1:0] imm;
  } idEx_t;

  typedef struct packed {
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              halt;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] storeData;
  } exMem_t;

  typedef struct packed {
    logic              regWrite;
    logic              halt;
    logic [4:0]        dest;
    logic [DATA_W-1:0] data;
  } memWb_t;

  logic [31:0]        imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]  regFile_q [32];

  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        ifIdInstr_q, ifIdInstr_d;
  logic               haltSeen_q, haltSeen_d;
  idEx_t              idEx_q, idEx_d;
  exMem_t             exMem_q, exMem_d;
  memWb_t             memWb_q, memWb_d;
  logic [DATA_W-1:0]  result_q;
  logic               wbValid_q;
  logic [4:0]         wbReg_q;
  logic               halted_q;

  logic [5:0]         idOp, idFunct;
  logic [4:0]         idRs, idRt, idRd;
  logic               loadUse;
  logic [DATA_W-1:0]  fwdA, fwdB, aluB, aluOut;
  logic [DMEM_AW-1:0] memAddr;

  assign idOp    = ifIdInstr_q[31:26];
  assign idRs    = ifIdInstr_q[25:21];
  assign idRt    = ifIdInstr_q[20:16];
  assign idRd    = ifIdInstr_q[15:11];
  assign idFunct = ifIdInstr_q[5:0];

  // A load still in EX cannot feed the instruction in ID; rt only counts for R-type and SW.
  assign loadUse = idEx_q.memRead && (idEx_q.dest != 5'd0) &&
                   ((idRs == idEx_q.dest) ||
                    (((idOp == OP_RTYPE) || (idOp == OP_SW)) && (idRt == idEx_q.dest)));

  always_comb begin
    pc_d        = pc_q + 1'b1;
    ifIdInstr_d = imem[pc_q];
    haltSeen_d  = haltSeen_q;
    if (loadUse) begin
      pc_d        = pc_q;
      ifIdInstr_d = ifIdInstr_q;
    end else if (haltSeen_q || (idOp == OP_HALT)) begin
      pc_d        = pc_q;
      ifIdInstr_d = '0;
      haltSeen_d  = 1'b1;
    end
  end

  // Register reads see a write-back happening on the same edge.
  always_comb begin
    idEx_d       = '0;
    idEx_d.rs    = idRs;
    idEx_d.rt    = idRt;
    idEx_d.rsVal = (memWb_q.regWrite && (memWb_q.dest == idRs)) ? memWb_q.data : regFile_q[idRs];
    idEx_d.rtVal = (memWb_q.regWrite && (memWb_q.dest == idRt)) ? memWb_q.data : regFile_q[idRt];
    idEx_d.imm   = DATA_W'($signed(ifIdInstr_q[15:0]));
    case (idOp)
      OP_RTYPE: begin
        idEx_d.dest = idRd;
        case (idFunct)
          FN_ADD: begin idEx_d.aluOp = ALU_ADD; idEx_d.regWrite = (idRd != 5'd0); end
          FN_SUB: begin idEx_d.aluOp = ALU_SUB; idEx_d.regWrite = (idRd != 5'd0); end
          FN_AND: begin idEx_d.aluOp = ALU_AND; idEx_d.regWrite = (idRd != 5'd0); end
          FN_OR:  begin idEx_d.aluOp = ALU_OR;  idEx_d.regWrite = (idRd != 5'd0); end
          default: idEx_d.regWrite = 1'b0;
        endcase
      end
      OP_ADDI: begin
        idEx_d.dest     = idRt;
        idEx_d.useImm   = 1'b1;
        idEx_d.regWrite = (idRt != 5'd0);
      end
      OP_LW: begin
        idEx_d.dest     = idRt;
        idEx_d.useImm   = 1'b1;
        idEx_d.memRead  = 1'b1;
        idEx_d.regWrite = (idRt != 5'd0);
      end
      OP_SW: begin
        idEx_d.useImm   = 1'b1;
        idEx_d.memWrite = 1'b1;
      end
      OP_HALT: idEx_d.halt = 1'b1;
      default: idEx_d.regWrite = 1'b0;
    endcase
    if (loadUse) idEx_d = '0;
  end

  // Forwarding: the younger EX/MEM result wins over MEM/WB, which wins over the register read.
  always_comb begin
    if (exMem_q.regWrite && (exMem_q.dest == idEx_q.rs))      fwdA = exMem_q.alu;
    else if (memWb_q.regWrite && (memWb_q.dest == idEx_q.rs)) fwdA = memWb_q.data;
    else                                                      fwdA = idEx_q.rsVal;
    if (exMem_q.regWrite && (exMem_q.dest == idEx_q.rt))      fwdB = exMem_q.alu;
    else if (memWb_q.regWrite && (memWb_q.dest == idEx_q.rt)) fwdB = memWb_q.data;
    else                                                      fwdB = idEx_q.rtVal;
    aluB = idEx_q.useImm ? idEx_q.imm : fwdB;
    case (idEx_q.aluOp)
      ALU_SUB: aluOut = fwdA - aluB;
      ALU_AND: aluOut = fwdA & aluB;
      ALU_OR:  aluOut = fwdA | aluB;
      default: aluOut = fwdA + aluB;
    endcase
    exMem_d           = '0;
    exMem_d.regWrite  = idEx_q.regWrite;
    exMem_d.memRead   = idEx_q.memRead;
    exMem_d.memWrite  = idEx_q.memWrite;
    exMem_d.halt      = idEx_q.halt;
    exMem_d.dest      = idEx_q.dest;
    exMem_d.alu       = aluOut;
    exMem_d.storeData = fwdB;
  end

  assign memAddr = exMem_q.alu[DMEM_AW-1:0];

  always_comb begin
    memWb_d          = '0;
    memWb_d.regWrite = exMem_q.regWrite;
    memWb_d.halt     = exMem_q.halt;
    memWb_d.dest     = exMem_q.dest;
    memWb_d.data     = exMem_q.memRead ? dmem[memAddr] : exMem_q.alu;
  end

  // Memories are deliberately outside the reset domain so programs and data survive reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
    if (exMem_q.memWrite) dmem[memAddr] <= exMem_q.storeData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      ifIdInstr_q <= '0;
      haltSeen_q  <= 1'b0;
      idEx_q      <= '0;
      exMem_q     <= '0;
      memWb_q     <= '0;
      for (int i = 0; i < 32; i++) regFile_q[i] <= '0;
      result_q    <= '0;
      wbValid_q   <= 1'b0;
      wbReg_q     <= '0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifIdInstr_q <= ifIdInstr_d;
      haltSeen_q  <= haltSeen_d;
      idEx_q      <= idEx_d;
      exMem_q     <= exMem_d;
      memWb_q     <= memWb_d;
      wbValid_q   <= memWb_q.regWrite;
      if (memWb_q.regWrite) begin
        regFile_q[memWb_q.dest] <= memWb_q.data;
        result_q                <= memWb_q.data;
        wbReg_q                 <= memWb_q.dest;
      end
      if (memWb_q.halt) halted_q <= 1'b1;
    end
  end

  assign bus.result   = result_q;
  assign bus.wb_valid = wbValid_q;
  assign bus.wb_reg   = wbReg_q;
  assign bus.pc       = pc_q;
  assign bus.stall    = loadUse;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_pipeline_core.sv
// Self-checking bench for pipeline_core: expected write-backs are queued when a program
// is loaded and compared against what the core retires, edge by edge after reset release.
module tb_pipeline_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_core_if #(.DATA_W(32), .IMEM_AW(4)) bus ();
  pipeline_core_if #(.DATA_W(32), .IMEM_AW(2)) bus4 ();

  pipeline_core #(.DATA_W(32), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pipeline_core #(.DATA_W(32), .IMEM_DEPTH(4), .DMEM_DEPTH(16)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
    int          edgeNum;
  } wbRec_t;

  wbRec_t      expQ[$];
  wbRec_t      obsQ[$];
  int          assertions = 0;
  int          failures = 0;
  int          stallCount, firstStallEdge, haltEdge;
  logic [3:0]  pcAt [0:63];
  logic [31:0] progBuf [16];

  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100, FN_OR = 6'b100101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  function automatic logic [31:0] rInstr(input logic [5:0] funct, input int rd, input int rs, input int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, funct};
  endfunction

  function automatic logic [31:0] iInstr(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic pushExp(input int r, input logic [31:0] v, input int e);
    wbRec_t x;
    x.r = 5'(r);
    x.v = v;
    x.edgeNum = e;
    expQ.push_back(x);
  endtask

  task automatic clearProg();
    for (int i = 0; i < 16; i++) progBuf[i] = 32'h0;
  endtask

  // Hold reset, load progBuf, then release on a falling edge so the next rising edge is edge 1.
  task automatic applyStimulus();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_addr  = 4'(i);
      bus.imem_wdata = progBuf[i];
      @(negedge clk);
    end
    bus.imem_we = 1'b0;
    reset = 1'b1;
  endtask

  task automatic collect(input int cycles);
    wbRec_t x;
    obsQ.delete();
    stallCount = 0;
    firstStallEdge = -1;
    haltEdge = -1;
    for (int e = 1; e <= cycles; e++) begin
      @(posedge clk);
      #1;
      pcAt[e] = bus.pc;
      if (bus.wb_valid === 1'b1) begin
        x.r = bus.wb_reg;
        x.v = bus.result;
        x.edgeNum = e;
        obsQ.push_back(x);
      end
      if (bus.stall === 1'b1) begin
        stallCount++;
        if (firstStallEdge < 0) firstStallEdge = e;
      end
      if (bus.halted === 1'b1 && haltEdge < 0) haltEdge = e;
    end
  endtask

  task automatic test_reset();
    bus.imem_we = 1'b0;
    bus4.imem_we = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    assertions++;
    if (bus.pc !== 4'd0 || bus.stall !== 1'b0 || bus.halted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got pc=%0d stall=%b halted=%b, want 0 0 0", bus.pc, bus.stall, bus.halted);
    end
    assertions++;
    if (bus.result !== 32'd0 || bus.wb_valid !== 1'b0 || bus.wb_reg !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_wb: got result=%h valid=%b reg=%0d, want 0 0 0", bus.result, bus.wb_valid, bus.wb_reg);
    end
  endtask

  task automatic test_alu_basic();
    wbRec_t e, o;
    clearProg();
    progBuf[0] = iInstr(OP_ADDI, 1, 0, 5);
    progBuf[1] = iInstr(OP_ADDI, 2, 0, 3);
    progBuf[2] = rInstr(FN_ADD, 3, 1, 2);
    progBuf[3] = rInstr(FN_SUB, 4, 1, 2);
    progBuf[4] = HALT;
    pushExp(1, 32'd5, 5); pushExp(2, 32'd3, 6); pushExp(3, 32'd8, 7); pushExp(4, 32'd2, 8);
    applyStimulus();
    collect(14);
    assertions++;
    if (obsQ.size() != expQ.size()) begin
      failures++;
      $display("[TB] FAIL basic_count: got %0d writes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertions++;
      if (o.r !== e.r || o.v !== e.v || o.edgeNum != e.edgeNum) begin
        failures++;
        $display("[TB] FAIL basic_wb: got r%0d=%h @%0d, want r%0d=%h @%0d", o.r, o.v, o.edgeNum, e.r, e.v, e.edgeNum);
      end
    end
    expQ.delete();
    assertions++;
    if (stallCount != 0 || haltEdge != 9) begin
      failures++;
      $display("[TB] FAIL basic_halt: got stalls=%0d haltEdge=%0d, want 0 9", stallCount, haltEdge);
    end
    assertions++;
    if (pcAt[1] !== 4'd1 || pcAt[5] !== 4'd5 || pcAt[14] !== 4'd5) begin
      failures++;
      $display("[TB] FAIL basic_pc: got %0d/%0d/%0d, want 1/5/5", pcAt[1], pcAt[5], pcAt[14]);
    end
  endtask

  task automatic test_mid_reset();
    wbRec_t e, o;
    reset = 1'b0;
    #1;
    assertions++;
    if (bus.halted !== 1'b0 || bus.result !== 32'd0 || bus.pc !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_after_halt: got halted=%b result=%h pc=%0d, want 0 0 0", bus.halted, bus.result, bus.pc);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    assertions++;
    if (bus.pc !== 4'd0 || bus.wb_valid !== 1'b0 || bus.stall !== 1'b0 || bus.halted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_clear: got pc=%0d valid=%b stall=%b halted=%b, want 0", bus.pc, bus.wb_valid, bus.stall, bus.halted);
    end
    @(negedge clk);
    reset = 1'b1;
    pushExp(1, 32'd5, 5); pushExp(2, 32'd3, 6); pushExp(3, 32'd8, 7); pushExp(4, 32'd2, 8);
    collect(12);
    assertions++;
    if (obsQ.size() != expQ.size() || haltEdge != 9) begin
      failures++;
      $display("[TB] FAIL midreset_rerun: got %0d writes haltEdge=%0d, want %0d 9", obsQ.size(), haltEdge, expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertions++;
      if (o.r !== e.r || o.v !== e.v || o.edgeNum != e.edgeNum) begin
        failures++;
        $display("[TB] FAIL midreset_wb: got r%0d=%h @%0d, want r%0d=%h @%0d", o.r, o.v, o.edgeNum, e.r, e.v, e.edgeNum);
      end
    end
    expQ.delete();
  endtask

  task automatic test_load_use();
    wbRec_t e, o;
    clearProg();
    progBuf[0] = iInstr(OP_ADDI, 1, 0, 7);
    progBuf[1] = iInstr(OP_SW, 1, 0, 4);
    progBuf[2] = iInstr(OP_LW, 2, 0, 4);
    progBuf[3] = rInstr(FN_ADD, 3, 2, 2);
    progBuf[4] = HALT;
    pushExp(1, 32'd7, 5); pushExp(2, 32'd7, 7); pushExp(3, 32'd14, 9);
    applyStimulus();
    collect(14);
    assertions++;
    if (obsQ.size() != expQ.size()) begin
      failures++;
      $display("[TB] FAIL loaduse_count: got %0d writes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertions++;
      if (o.r !== e.r || o.v !== e.v || o.edgeNum != e.edgeNum) begin
        failures++;
        $display("[TB] FAIL loaduse_wb: got r%0d=%h @%0d, want r%0d=%h @%0d", o.r, o.v, o.edgeNum, e.r, e.v, e.edgeNum);
      end
    end
    expQ.delete();
    assertions++;
    if (stallCount != 1 || firstStallEdge != 4 || haltEdge != 10) begin
      failures++;
      $display("[TB] FAIL loaduse_stall: got stalls=%0d at %0d haltEdge=%0d, want 1 at 4, 10", stallCount, firstStallEdge, haltEdge);
    end
  endtask

  task automatic test_r0();
    wbRec_t e, o;
    clearProg();
    progBuf[0] = iInstr(OP_ADDI, 0, 0, 9);
    progBuf[1] = rInstr(FN_ADD, 5, 0, 0);
    progBuf[2] = HALT;
    pushExp(5, 32'd0, 6);
    applyStimulus();
    collect(12);
    assertions++;
    if (obsQ.size() != expQ.size() || haltEdge != 7) begin
      failures++;
      $display("[TB] FAIL r0_count: got %0d writes haltEdge=%0d, want %0d 7", obsQ.size(), haltEdge, expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertions++;
      if (o.r !== e.r || o.v !== e.v || o.edgeNum != e.edgeNum) begin
        failures++;
        $display("[TB] FAIL r0_wb: got r%0d=%h @%0d, want r%0d=%h @%0d", o.r, o.v, o.edgeNum, e.r, e.v, e.edgeNum);
      end
    end
    expQ.delete();
  endtask

  task automatic test_negative();
    wbRec_t e, o;
    clearProg();
    progBuf[0] = iInstr(OP_ADDI, 1, 0, 1);
    progBuf[1] = rInstr(FN_SUB, 2, 0, 1);
    progBuf[2] = iInstr(OP_ADDI, 3, 0, -2);
    progBuf[3] = rInstr(FN_AND, 4, 2, 3);
    progBuf[4] = HALT;
    pushExp(1, 32'd1, 5); pushExp(2, 32'hFFFF_FFFF, 6); pushExp(3, 32'hFFFF_FFFE, 7); pushExp(4, 32'hFFFF_FFFE, 8);
    applyStimulus();
    collect(12);
    assertions++;
    if (obsQ.size() != expQ.size()) begin
      failures++;
      $display("[TB] FAIL neg_count: got %0d writes, want %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertions++;
      if (o.r !== e.r || o.v !== e.v || o.edgeNum != e.edgeNum) begin
        failures++;
        $display("[TB] FAIL neg_wb: got r%0d=%h @%0d, want r%0d=%h @%0d", o.r, o.v, o.edgeNum, e.r, e.v, e.edgeNum);
      end
    end
    expQ.delete();
  endtask

  // Store at a negative offset must wrap to word 15; the OR needs both forwarding paths at once.
  task automatic test_mem_wrap();
    wbRec_t e, o;
    clearProg();
    progBuf[0] = iInstr(OP_ADDI, 1, 0, 21);
    progBuf[1] = iInstr(OP_SW, 1, 0, -1);
    progBuf[2] = iInstr(OP_LW, 2, 0, 15);
    progBuf[3] = iInstr(OP_ADDI, 4, 0, 10);
    progBuf[4] = rInstr(FN_OR, 3, 2, 4);
    progBuf[5] = HALT;
    pushExp(1, 32'd21, 5); pushExp(2, 32'd21, 7); pushExp(4, 32'd10, 8); pushExp(3, 32'd31, 9);
    applyStimulus();
    collect(14);
    assertions++;
    if (obsQ.size() != expQ.size() || stallCount != 0 || haltEdge != 10) begin
      failures++;
      $display("[TB] FAIL memwrap_ctrl: got %0d writes stalls=%0d haltEdge=%0d, want %0d 0 10", obsQ.size(), stallCount, haltEdge, expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front();
      assertions++;
      if (o.r !== e.r || o.v !== e.v || o.edgeNum != e.edgeNum) begin
        failures++;
        $display("[TB] FAIL memwrap_wb: got r%0d=%h @%0d, want r%0d=%h @%0d", o.r, o.v, o.edgeNum, e.r, e.v, e.edgeNum);
      end
    end
    expQ.delete();
  endtask

  task automatic test_pc_wrap();
    wbRec_t e;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus4.imem_we    = 1'b1;
      bus4.imem_addr  = 2'(i);
      bus4.imem_wdata = iInstr(OP_ADDI, 1, 1, 1);
      @(negedge clk);
    end
    bus4.imem_we = 1'b0;
    for (int k = 5; k <= 10; k++) pushExp(1, 32'(k - 4), k);
    reset = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      assertions++;
      if (bus4.pc !== 2'(c % 4)) begin
        failures++;
        $display("[TB] FAIL wrap_pc: edge %0d got pc=%0d, want %0d", c, bus4.pc, c % 4);
      end
      if (bus4.wb_valid === 1'b1) begin
        assertions++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL wrap_extra: got r%0d=%h @%0d, want no write", bus4.wb_reg, bus4.result, c);
        end else begin
          e = expQ.pop_front();
          if (bus4.wb_reg !== e.r || bus4.result !== e.v || c != e.edgeNum) begin
            failures++;
            $display("[TB] FAIL wrap_wb: got r%0d=%h @%0d, want r%0d=%h @%0d", bus4.wb_reg, bus4.result, c, e.r, e.v, e.edgeNum);
          end
        end
      end
    end
    assertions++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrap_missing: got %0d writes pending, want 0", expQ.size());
    end
    expQ.delete();
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_mid_reset();
    test_load_use();
    test_r0();
    test_negative();
    test_mem_wrap();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/pipeline_core.md
# pipeline_core

Parametrised five-stage (IF/ID/EX/MEM/WB) in-order processor core. It is the successor to the team's four-stage prototype pipeline and adds:
- configurable data width and memory depths;
- a data memory with load and store;
- an immediate add;
- full EX forwarding and one-cycle load-use stall;
- HALT, and a program-load port.

It sits at the top of the processor subsystem and exposes write-back results for observation.

## Interface
Parameters:
- DATA_W, 32, datapath/register width; legal values 16..64.
- IMEM_DEPTH, 16, instruction words (power of 2); IMEM_AW = clog2(IMEM_DEPTH).
- DMEM_DEPTH, 16, data words (power of 2); DMEM_AW = clog2(DMEM_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_we  in  1  program-load write enable.
- imem_addr  in  IMEM_AW  program-load word address.
- imem_wdata  in  32  program-load instruction.
- result  out  DATA_W  data written back by the most recent retiring instruction.
- wb_valid  out  1  high for one cycle per register-writing instruction retired.
- wb_reg  out  5  destination register of that write.
- pc  out  IMEM_AW  current fetch address.
- stall  out  1  load-use stall active this cycle.
- halted  out  1  sticky; HALT has retired.

## Operation
- Instruction format is 32 bits, MIPS-style: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- Supported instructions:
  - op 000000 R-type: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR; writes rd.
  - op 001000 ADDI: rt = rs + sext(imm).
  - op 100011 LW: rt = dmem[(rs + sext(imm))[DMEM_AW-1:0]].
  - op 101011 SW: dmem[(rs + sext(imm))[DMEM_AW-1:0]] = rt.
  - op 111111 HALT.
  - Any other op or funct is a NOP: no register write, no memory write.
- Arithmetic is modulo 2^DATA_W. sext extends imm[15] to DATA_W bits. Data addresses take the low DMEM_AW bits of the sum and wrap.
- Register file: 32 × DATA_W, all cleared by reset.
  - r0 reads 0 always; writes to r0 are dropped, and wb_valid stays 0 for them.
  - A WB write and an ID read of the same register in the same cycle return the new value.
- Memories:
  - imem and dmem are not affected by reset.
  - imem write happens on the clk edge whenever imem_we=1, including while reset is low.
  - dmem is read combinationally in MEM and written on the edge.
- Forwarding into EX operands: EX/MEM has priority, then MEM/WB, then the register-file value. Never forward from a register-0 destination or a non-writing instruction.
- Load-use hazard: ID/EX holds LW with rt≠0, and the ID instruction reads that register (rs for all instructions; rt for R-type and SW). Response:
  - pc and IF/ID hold;
  - a bubble enters ID/EX;
  - stall=1 for exactly one cycle.
- HALT in ID:
  - pc freezes;
  - IF/ID is loaded with NOP from then on;
  - older instructions drain.
  - When HALT reaches WB, halted goes to 1 and stays there until reset.
- Without HALT, pc increments by 1 and wraps from IMEM_DEPTH-1 to 0.

## Timing
- Reset low clears immediately: all outputs, pc and pipeline registers go to 0 (NOP); halted=0, stall=0.
- First fetch occurs at the first rising edge after reset deasserts.
- Latency: the instruction fetched at edge k writes the register file and updates result, wb_reg and wb_valid at edge k+4.
- wb_valid is a one-cycle pulse. result holds its value between pulses.
- Throughput is one instruction per cycle. A load-use hazard adds one bubble; dependent ALU instructions need no bubble.
- Reset asserted mid-program: the pipeline is flushed asynchronously. After release, execution restarts at pc 0 with zeroed registers. dmem keeps its contents.

## Test plan
1. Load ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; SUB r4,r1,r2; HALT, then release reset → wb_valid on four consecutive cycles, starting 5 edges after release, with (reg,result) = (1,5),(2,3),(3,8),(4,2). halted=1 one cycle later; pc frozen; stall never high.
2. ADDI r1,r0,7; SW r1,4(r0); LW r2,4(r0); ADD r3,r2,r2; HALT → stall high exactly one cycle; r3 write result=14, one cycle later than the no-stall slot.
3. ADDI r0,r0,9; ADD r5,r0,r0 → no wb_valid for r0; r5 result=0.
4. DATA_W=32: ADDI r1,r0,1; SUB r2,r0,r1; ADDI r3,r0,-2; AND r4,r2,r3 → results 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFE.
5. Run test 1 and pull reset low two edges after release → outputs 0 immediately. Release again → identical result sequence repeats.
6. IMEM_DEPTH=4, program of ADDI r1,r1,1 ×4 with no HALT → pc sequence 1,2,3,0,1…; r1 results 1,2,3,4,5… (forwarded each cycle).
